// File: rtl/squat_cpu_lut_slave_pkg.sv
// Shared definitions for the CPU bus slave and its VPI forwarding table:
// the cell configuration record, bus mode and CPU-side FSM encodings.
package squat_cpu_lut_slave_pkg;

    // Number of transmit ports covered by the forwarding mask.
    localparam int TX_PORTS = 4;

    // Table address / VPI width on the CPU and lookup ports.
    localparam int ADDR_W = 12;

    // One forwarding-table entry: port mask plus the VPI to stamp on egress.
    typedef struct packed {
        logic [TX_PORTS-1:0] FWD;
        logic [11:0]         VPI;
    } CellCfgType;

    localparam int CELL_W = $bits(CellCfgType);

    // Static CPU bus personality selected by BusMode.
    typedef enum logic {
        MOTOROLA = 1'b0,
        INTEL    = 1'b1
    } bus_mode_e;

    // CPU-side access sequencer states.
    typedef enum logic [2:0] {
        INIT    = 3'd0,
        IDLE    = 3'd1,
        ACCESS  = 3'd2,
        ACK     = 3'd3,
        RELEASE = 3'd4
    } cpu_state_e;

    // True when a 12-bit table address selects a physically present entry.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr, input int depth);
        return int'(addr) < depth;
    endfunction

endpackage

// File: rtl/squat_cpu_lut_slave_sync.sv
// Multi-flop synchroniser for the asynchronous CPU bus control pins.
// All stages reset to 1 so the synchronised strobes start out inactive.
module squat_cpu_lut_slave_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // Shift the raw pins through STAGES flops; reset forces the inactive level.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '1;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/squat_cpu_lut_slave.sv
// CPU bus slave owning the VPI-indexed forwarding table.
// Handles Intel (Rd/Wr/Rdy) and Motorola (DS/RW/Dtack) CPU cycles, zero-fills
// the table after reset, and offers a one-cycle lookup port to the datapath.
//
// CPU handshake: an access is accepted once the synchronised strobe is seen
// low with Sel low; ack stays asserted until the synchronised strobe (or Sel)
// goes high, then drops for one RELEASE cycle before the next access.
// The lookup port has no backpressure: every lu_req gets lu_vld next cycle.
module squat_cpu_lut_slave
    import squat_cpu_lut_slave_pkg::*;
#(
    parameter int DEPTH       = 4096,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              BusMode,
    input  logic [11:0]       Addr,
    input  logic              Sel,
    input  CellCfgType        DataIn,
    output CellCfgType        DataOut,
    input  logic              Rd_DS,
    input  logic              Wr_RW,
    output logic              Rdy_Dtack,
    input  logic              lu_req,
    input  logic [11:0]       lu_vpi,
    output logic              lu_vld,
    output CellCfgType        lu_cfg,
    output logic              init_done,
    output cpu_state_e        dbg_state
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [11:0] LAST_IDX = 12'(DEPTH - 1);

    // Synchronised bus controls
    logic [2:0] sync_out;
    logic       sel_s;
    logic       rd_s;
    logic       wr_s;

    // Access decode
    logic       strobe_active;
    logic       acc_req;
    logic       acc_wr;

    // FSM state and registered outputs
    cpu_state_e  state_q;
    logic [11:0] init_cnt_q;
    logic [11:0] addr_q;
    CellCfgType  wdata_q;
    logic        wr_q;
    logic        ack_q;
    CellCfgType  data_out_q;
    logic        lu_vld_q;
    CellCfgType  lu_cfg_q;
    logic        init_done_q;

    // Table storage and its single muxed write port
    CellCfgType  mem [DEPTH];
    logic        mem_we;
    logic [AW-1:0] mem_widx;
    CellCfgType  mem_wdata;
    CellCfgType  cpu_rd;
    CellCfgType  lu_rd;

    squat_cpu_lut_slave_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (3)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i ({Sel, Rd_DS, Wr_RW}),
        .q_o (sync_out)
    );

    assign sel_s = sync_out[2];
    assign rd_s  = sync_out[1];
    assign wr_s  = sync_out[0];

    // Decode bus mode: Intel needs exactly one strobe low, Motorola uses DS plus R/W.
    always_comb begin
        strobe_active = 1'b0;
        acc_req       = 1'b0;
        acc_wr        = 1'b0;
        if (bus_mode_e'(BusMode) == INTEL) begin
            strobe_active = !sel_s && (!rd_s || !wr_s);
            acc_req       = !sel_s && (rd_s != wr_s);
            acc_wr        = !wr_s;
        end else begin
            strobe_active = !sel_s && !rd_s;
            acc_req       = strobe_active;
            acc_wr        = !wr_s;
        end
    end

    // Write-port mux: zero-fill walks the table in INIT, CPU writes land in ACCESS.
    // Reset blocks any write so a write pending in ACCESS is dropped.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = init_cnt_q[AW-1:0];
        mem_wdata = '0;
        if (!rst) begin
            if (state_q == INIT) begin
                mem_we = 1'b1;
            end else if (state_q == ACCESS && wr_q && in_range(addr_q, DEPTH)) begin
                mem_we    = 1'b1;
                mem_widx  = addr_q[AW-1:0];
                mem_wdata = wdata_q;
            end
        end
    end

    // Table write port; the array itself is never reset, INIT clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    // Two read ports; out-of-range indices read as zero.
    assign cpu_rd = in_range(addr_q, DEPTH) ? mem[addr_q[AW-1:0]] : '0;
    assign lu_rd  = in_range(lu_vpi, DEPTH) ? mem[lu_vpi[AW-1:0]] : '0;

    // CPU access sequencer plus lookup pipeline register. Reads of mem here see
    // the pre-write contents, which gives read-first behaviour on collisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            ack_q       <= 1'b0;
            data_out_q  <= '0;
            lu_vld_q    <= 1'b0;
            lu_cfg_q    <= '0;
            init_done_q <= 1'b0;
        end else begin
            lu_vld_q <= lu_req;
            if (lu_req) begin
                lu_cfg_q <= (state_q == INIT) ? '0 : lu_rd;
            end

            case (state_q)
                INIT: begin
                    init_cnt_q <= init_cnt_q + 12'd1;
                    if (init_cnt_q == LAST_IDX) begin
                        state_q     <= IDLE;
                        init_done_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (acc_req) begin
                        addr_q  <= Addr;
                        wdata_q <= DataIn;
                        wr_q    <= acc_wr;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!wr_q) begin
                        data_out_q <= cpu_rd;
                    end
                    ack_q   <= 1'b1;
                    state_q <= ACK;
                end
                ACK: begin
                    if (!strobe_active) begin
                        ack_q   <= 1'b0;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    assign Rdy_Dtack = BusMode ? ack_q : ~ack_q;
    assign DataOut   = data_out_q;
    assign lu_vld    = lu_vld_q;
    assign lu_cfg    = lu_cfg_q;
    assign init_done = init_done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_squat_cpu_lut_slave.sv
// Bench for squat_cpu_lut_slave. Two instances share every input: a full
// 4096-entry table and a 256-entry table, so out-of-range behaviour is seen
// side by side with a real entry at the same address.
module tb_squat_cpu_lut_slave;
    import squat_cpu_lut_slave_pkg::*;

    localparam int SYNC    = 2;
    localparam int DEPTH_A = 4096;
    localparam int DEPTH_B = 256;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        bus_mode;
    logic [11:0] addr;
    logic        sel;
    CellCfgType  data_in;
    logic        rd_ds;
    logic        wr_rw;
    logic        lu_req;
    logic [11:0] lu_vpi;

    CellCfgType  a_data_out, b_data_out, a_lu_cfg, b_lu_cfg;
    logic        a_rdy, b_rdy, a_lu_vld, b_lu_vld, a_init_done, b_init_done;
    cpu_state_e  a_state, b_state;

    squat_cpu_lut_slave #(.DEPTH(DEPTH_A), .SYNC_STAGES(SYNC)) u_dut_a (
        .clk(clk), .rst(rst), .BusMode(bus_mode), .Addr(addr), .Sel(sel),
        .DataIn(data_in), .DataOut(a_data_out), .Rd_DS(rd_ds), .Wr_RW(wr_rw),
        .Rdy_Dtack(a_rdy), .lu_req(lu_req), .lu_vpi(lu_vpi), .lu_vld(a_lu_vld),
        .lu_cfg(a_lu_cfg), .init_done(a_init_done), .dbg_state(a_state)
    );

    squat_cpu_lut_slave #(.DEPTH(DEPTH_B), .SYNC_STAGES(SYNC)) u_dut_b (
        .clk(clk), .rst(rst), .BusMode(bus_mode), .Addr(addr), .Sel(sel),
        .DataIn(data_in), .DataOut(b_data_out), .Rd_DS(rd_ds), .Wr_RW(wr_rw),
        .Rdy_Dtack(b_rdy), .lu_req(lu_req), .lu_vpi(lu_vpi), .lu_vld(b_lu_vld),
        .lu_cfg(b_lu_cfg), .init_done(b_init_done), .dbg_state(b_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] ref_mem [4096];
    logic [15:0] last_rd_a;
    logic [15:0] last_rd_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Handshake line seen as a plain "ack asserted" flag in either bus mode.
    function automatic logic ack_on(input logic pin);
        return bus_mode ? pin : !pin;
    endfunction

    function automatic logic [15:0] exp_b(input logic [11:0] a);
        return (int'(a) < DEPTH_B) ? ref_mem[a] : 16'h0000;
    endfunction

    function automatic logic [15:0] exp_a(input logic [11:0] a);
        return ref_mem[a];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_bus();
        sel   = 1'b1;
        rd_ds = 1'b1;
        wr_rw = 1'b1;
    endtask

    task automatic drive_strobe(input logic wr);
        sel = 1'b0;
        if (bus_mode) begin
            if (wr) wr_rw = 1'b0;
            else    rd_ds = 1'b0;
        end else begin
            wr_rw = !wr;
            rd_ds = 1'b0;
        end
    endtask

    // Reset both tables, check reset outputs, time the zero-fill and probe a
    // lookup while the fill is still running.
    task automatic do_reset(input logic mode, input logic [11:0] lu_idx);
        int n;
        int nb;
        @(negedge clk);
        bus_mode = mode;
        rst      = 1'b1;
        lu_req   = 1'b0;
        idle_bus();
        @(negedge clk);
        chk("rst_dataout_a", a_data_out, 16'h0);
        chk("rst_dataout_b", b_data_out, 16'h0);
        chk("rst_lu_vld_a", a_lu_vld, 1'b0);
        chk("rst_init_done_a", a_init_done, 1'b0);
        chk("rst_init_done_b", b_init_done, 1'b0);
        chk("rst_ack_idle_a", a_rdy, mode ? 1'b0 : 1'b1);
        rst = 1'b0;
        n   = 0;
        nb  = -1;
        while (n < 5000 && !a_init_done) begin
            @(negedge clk);
            n++;
            if (b_init_done && nb < 0) nb = n;
            if (n == 10) begin
                lu_req = 1'b1;
                lu_vpi = lu_idx;
            end
            if (n == 11) begin
                chk("init_lu_vld_a", a_lu_vld, 1'b1);
                chk("init_lu_cfg_a", a_lu_cfg, 16'h0);
                chk("init_lu_cfg_b", b_lu_cfg, 16'h0);
                lu_req = 1'b0;
            end
        end
        chk("init_cycles_a", n, DEPTH_A);
        chk("init_cycles_b", nb, DEPTH_B);
        for (int i = 0; i < 4096; i++) ref_mem[i] = 16'h0000;
        last_rd_a = 16'h0000;
        last_rd_b = 16'h0000;
    endtask

    // One complete CPU cycle: strobe, wait for ack, capture data, release,
    // wait for ack to drop, then one idle cycle for RELEASE.
    task automatic cpu_access(input logic wr, input logic [11:0] a, input logic [15:0] d,
                              output int lat, output int rel,
                              output logic [15:0] rd_a, output logic [15:0] rd_b);
        @(negedge clk);
        addr    = a;
        data_in = d;
        drive_strobe(wr);
        lat = 0;
        while (lat < 20 && !ack_on(a_rdy)) begin
            @(negedge clk);
            lat++;
        end
        chk("ack_b", ack_on(b_rdy), 1'b1);
        rd_a = a_data_out;
        rd_b = b_data_out;
        idle_bus();
        rel = 0;
        while (rel < 20 && ack_on(a_rdy)) begin
            @(negedge clk);
            rel++;
        end
        @(negedge clk);
    endtask

    // CPU cycle checked against the reference model, which it then updates.
    task automatic access_check(input logic wr, input logic [11:0] a, input logic [15:0] d);
        int lat;
        int rel;
        logic [15:0] ra;
        logic [15:0] rb;
        cpu_access(wr, a, d, lat, rel, ra, rb);
        chk("ack_latency", lat, SYNC + 2);
        chk("ack_release", rel, SYNC + 1);
        if (wr) begin
            chk("wr_dataout_hold_a", ra, last_rd_a);
            chk("wr_dataout_hold_b", rb, last_rd_b);
            ref_mem[a] = d;
        end else begin
            chk("rd_data_a", ra, exp_a(a));
            chk("rd_data_b", rb, exp_b(a));
            last_rd_a = exp_a(a);
            last_rd_b = exp_b(a);
        end
    endtask

    function automatic logic [11:0] rand_addr();
        case ($urandom_range(0, 2))
            0:       return 12'($urandom_range(0, 15));
            1:       return 12'h100 + 12'($urandom_range(0, 15));
            default: return 12'($urandom_range(0, 4095));
        endcase
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        wr;
        logic [11:0] a;
        logic [15:0] d;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    vec_t vecs [10];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : main
        int          lat;
        int          rel;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        prev_req;
        logic [11:0] prev_vpi;
        int          bad;
        logic [15:0] old_v;

        rst      = 1'b1;
        bus_mode = 1'b1;
        addr     = '0;
        data_in  = '0;
        lu_req   = 1'b0;
        lu_vpi   = '0;
        idle_bus();

        // FWD = mask in [15:12], VPI in [11:0]; writes expect DataOut unchanged.
        vecs[0] = '{1'b1, 12'h005, 16'hA0AB, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 12'h005, 16'h0000, 16'hA0AB, 16'hA0AB};
        vecs[2] = '{1'b1, 12'h300, 16'h5123, 16'hA0AB, 16'hA0AB};
        vecs[3] = '{1'b0, 12'h300, 16'h0000, 16'h5123, 16'h0000};
        vecs[4] = '{1'b0, 12'h000, 16'h0000, 16'h0000, 16'h0000};
        vecs[5] = '{1'b1, 12'h0FF, 16'h3FFF, 16'h0000, 16'h0000};
        vecs[6] = '{1'b0, 12'h0FF, 16'h0000, 16'h3FFF, 16'h3FFF};
        vecs[7] = '{1'b1, 12'h100, 16'h1234, 16'h3FFF, 16'h3FFF};
        vecs[8] = '{1'b0, 12'h100, 16'h0000, 16'h1234, 16'h0000};
        vecs[9] = '{1'b0, 12'h005, 16'h0000, 16'hA0AB, 16'hA0AB};

        // ---- Intel phase ----
        do_reset(1'b1, 12'd100);

        for (int i = 0; i < 10; i++) begin
            cpu_access(vecs[i].wr, vecs[i].a, vecs[i].d, lat, rel, ra, rb);
            chk("vec_latency", lat, SYNC + 2);
            chk("vec_release", rel, SYNC + 1);
            chk($sformatf("vec%0d_data_a", i), ra, vecs[i].exp_a);
            chk($sformatf("vec%0d_data_b", i), rb, vecs[i].exp_b);
            if (vecs[i].wr) begin
                ref_mem[vecs[i].a] = vecs[i].d;
            end else begin
                last_rd_a = vecs[i].exp_a;
                last_rd_b = vecs[i].exp_b;
            end
        end

        // Lookup colliding with a CPU write in its ACCESS cycle sees the old value.
        access_check(1'b1, 12'h010, 16'h0111);
        old_v = ref_mem[12'h010];
        @(negedge clk);
        addr    = 12'h010;
        data_in = 16'h5ABC;
        drive_strobe(1'b1);
        repeat (SYNC + 1) @(negedge clk);
        lu_req = 1'b1;
        lu_vpi = 12'h010;
        @(negedge clk);
        chk("collide_ack", ack_on(a_rdy), 1'b1);
        chk("collide_lu_vld", a_lu_vld, 1'b1);
        chk("collide_old_a", a_lu_cfg, old_v);
        chk("collide_old_b", b_lu_cfg, old_v);
        @(negedge clk);
        chk("collide_new_a", a_lu_cfg, 16'h5ABC);
        chk("collide_new_b", b_lu_cfg, 16'h5ABC);
        lu_req = 1'b0;
        idle_bus();
        rel = 0;
        while (rel < 20 && ack_on(a_rdy)) begin
            @(negedge clk);
            rel++;
        end
        chk("collide_release", rel, SYNC + 1);
        @(negedge clk);
        ref_mem[12'h010] = 16'h5ABC;

        // Random Intel traffic
        for (int i = 0; i < 30; i++) begin
            access_check(1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
        end

        // Random back-to-back lookups against the model
        prev_req = 1'b0;
        prev_vpi = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("rand_lu_vld", a_lu_vld, prev_req);
                if (prev_req) begin
                    chk("rand_lu_cfg_a", a_lu_cfg, exp_a(prev_vpi));
                    chk("rand_lu_cfg_b", b_lu_cfg, exp_b(prev_vpi));
                end
            end
            prev_req = 1'($urandom_range(0, 3) != 0);
            prev_vpi = rand_addr();
            lu_req   = prev_req;
            lu_vpi   = prev_vpi;
        end
        @(negedge clk);
        lu_req = 1'b0;

        // ---- Motorola phase ----
        do_reset(1'b0, 12'h005);
        chk("dtack_idle", a_rdy, 1'b1);
        access_check(1'b1, 12'hFFF, 16'h9F00);
        chk("dtack_idle_after_wr", a_rdy, 1'b1);
        access_check(1'b0, 12'hFFF, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            access_check(1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
        end
        access_check(1'b1, 12'h0FF, 16'h7777);

        // Reset during ACK of a read
        @(negedge clk);
        addr = 12'hFFF;
        drive_strobe(1'b0);
        lat = 0;
        while (lat < 20 && !ack_on(a_rdy)) begin
            @(negedge clk);
            lat++;
        end
        chk("rstack_latency", lat, SYNC + 2);
        rst = 1'b1;
        @(negedge clk);
        chk("rstack_dtack_a", a_rdy, 1'b1);
        chk("rstack_dtack_b", b_rdy, 1'b1);
        chk("rstack_init_done", a_init_done, 1'b0);
        idle_bus();
        do_reset(1'b0, 12'h0FF);

        // Sweep every index through the lookup port; everything must be zero.
        bad = 0;
        for (int i = 0; i <= 4096; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (!a_lu_vld || a_lu_cfg != 16'h0 || b_lu_cfg != 16'h0) bad++;
            end
            lu_req = (i < 4096);
            lu_vpi = 12'(i);
        end
        chk("sweep_nonzero", bad, 0);
        lu_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
